// File: rtl/gf180mcu_fd_sc_mcu9t5v0__antenna_deglitch_if.sv
// Channel bundle between raw pad inputs and the deglitch block.
// Latency: none, the interface holds wires only.
// Backpressure: none, these are level signals and carry no handshake.
interface gf180mcu_fd_sc_mcu9t5v0__antenna_deglitch_if #(
    parameter int N = 4
);
    logic [N-1:0] I;
    logic         EN;
    logic         CLR;
    logic [N-1:0] Z;
    logic [N-1:0] RISE;
    logic [N-1:0] FALL;
    logic [N-1:0] ACT;

    // Driver side: supplies the raw inputs and controls, and observes the results.
    modport master (
        output I, EN, CLR,
        input  Z, RISE, FALL, ACT
    );

    // Deglitch block side.
    modport slave (
        input  I, EN, CLR,
        output Z, RISE, FALL, ACT
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__antenna_deglitch.sv
// Per-channel synchroniser followed by a consecutive-cycle deglitch filter, with edge pulses and sticky activity flags.
// Latency: SYNC_STAGES+FILT_CYCLES edges from a stable input change to Z. In bypass mode it is SYNC_STAGES+1 edges.
// Backpressure: none. EN=0 freezes Z and discards any pending qualification count.
module gf180mcu_fd_sc_mcu9t5v0__antenna_deglitch #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int MODE        = 1
) (
`ifdef USE_POWER_PINS
    inout wire VDD,
    inout wire VSS,
`endif
    input logic CLK,
    input logic RST,
    gf180mcu_fd_sc_mcu9t5v0__antenna_deglitch_if.slave bus
);
    // Bypass is a filter of length one, so both modes share one datapath.
    localparam int FILT = (MODE == 0) ? 1 : FILT_CYCLES;
    localparam int CW   = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(FILT - 1);

    logic [N-1:0]  sync_q [SYNC_STAGES];
    logic [CW-1:0] cnt_q  [N];
    logic [N-1:0]  z_q;
    logic [N-1:0]  rise_q;
    logic [N-1:0]  fall_q;
    logic [N-1:0]  act_q;
    logic [N-1:0]  s;
    logic [N-1:0]  differ;
    logic [N-1:0]  hit;

    assign s      = sync_q[SYNC_STAGES-1];
    assign differ = s ^ z_q;

    // The synchroniser chain always runs, independent of EN, so it is settled whenever filtering resumes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= bus.I;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // A channel qualifies when it has differed from Z for the full filter length.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N; i++) begin
            hit[i] = bus.EN && differ[i] && (cnt_q[i] == LAST);
        end
    end

    // Qualification counters restart whenever s agrees with Z, on a qualifying edge, or while disabled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!bus.EN || !differ[i] || hit[i]) cnt_q[i] <= '0;
                else                                  cnt_q[i] <= cnt_q[i] + CW'(1);
            end
        end
    end

    // Z follows s on qualification, and the edge pulses fire in the first cycle Z shows the new value.
    // A set of ACT takes priority over CLR in the same cycle, so that activity is never lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            z_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
            act_q  <= '0;
        end else begin
            z_q    <= z_q ^ hit;
            rise_q <= hit & s;
            fall_q <= hit & ~s;
            act_q  <= (act_q & ~{N{bus.CLR}}) | hit;
        end
    end

    assign bus.Z    = z_q;
    assign bus.RISE = rise_q;
    assign bus.FALL = fall_q;
    assign bus.ACT  = act_q;
endmodule
